fifo_rr_ctrl: RTL and testbench



---
 rtl/fifo_rr_ctrl_pkg.sv | 20 ++
 rtl/fifo_rr_ctrl_rr_pick.sv | 34 +++
 rtl/fifo_rr_ctrl.sv | 109 ++++++++++
 tb/tb_fifo_rr_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_ctrl_pkg.sv
// Shared types and sizing helpers for the round-robin FIFO write/read controller.
package fifo_rr_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } wr_state_t;

    localparam int FIFO_DEPTH      = 16;
    localparam int FIFO_FULL_LEVEL = 15;

    function automatic int owner_w(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    function automatic int bcnt_w(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/fifo_rr_ctrl_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from last_owner+1.
module rr_pick
    import fifo_rr_ctrl_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int OWNER_W = owner_w(N_REQ)
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [OWNER_W-1:0] last_owner,
    output logic [OWNER_W-1:0] winner,
    output logic               any_req
);

    logic [OWNER_W-1:0] cand;

    function automatic logic [OWNER_W-1:0] wrap(input logic [OWNER_W:0] v);
        return OWNER_W'(v % (OWNER_W+1)'(N_REQ));
    endfunction

    // Scanning from the farthest candidate down lets the nearest one win without a break.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = wrap({1'b0, last_owner} + (OWNER_W+1)'(i));
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/fifo_rr_ctrl.sv
// Shares one FIFO between N_REQ producers (round-robin, burst-locked writes) and one consumer.
module fifo_rr_ctrl
    import fifo_rr_ctrl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    pop_req,
    output logic                    pop_ack,
    output logic                    rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    fifo_wr,
    output logic                    fifo_rd,
    output logic [DATA_W-1:0]       fifo_din,
    input  logic [DATA_W-1:0]       fifo_dout,
    input  logic                    fifo_full,
    input  logic                    fifo_empty
);

    localparam int OWNER_W = owner_w(N_REQ);
    localparam int BCNT_W  = bcnt_w(MAX_BURST);
    localparam logic [OWNER_W-1:0] LAST_INIT  = OWNER_W'(N_REQ - 1);
    localparam logic [BCNT_W-1:0]  BURST_LAST = BCNT_W'(MAX_BURST - 1);

    wr_state_t          state;
    logic [OWNER_W-1:0] owner;
    logic [OWNER_W-1:0] last_owner;
    logic [OWNER_W-1:0] pick_idx;
    logic [BCNT_W-1:0]  burst_cnt;
    logic               pick_any;
    logic               owner_valid;
    logic               wr_fire;

    rr_pick #(
        .N_REQ   (N_REQ),
        .OWNER_W (OWNER_W)
    ) u_pick (
        .req        (req_valid),
        .last_owner (last_owner),
        .winner     (pick_idx),
        .any_req    (pick_any)
    );

    assign owner_valid = req_valid[owner];
    assign wr_fire     = (state == BURST) && owner_valid && !fifo_full;
    assign fifo_wr     = wr_fire;

    always_comb begin
        req_ready = '0;
        fifo_din  = '0;
        if (state == BURST) begin
            req_ready[owner] = !fifo_full;
            fifo_din         = req_data[32'(owner)*DATA_W +: DATA_W];
        end
    end

    // A full FIFO stalls the burst in place: owner and beat count are held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= LAST_INIT;
            burst_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner     <= pick_idx;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (!owner_valid) begin
                        state      <= IDLE;
                        last_owner <= owner;
                    end else if (wr_fire) begin
                        burst_cnt <= burst_cnt + BCNT_W'(1);
                        if (burst_cnt == BURST_LAST) begin
                            state      <= IDLE;
                            last_owner <= owner;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reads are gated by rst too so every output is quiet while reset is held.
    assign fifo_rd = pop_req && !fifo_empty && !rst;
    assign pop_ack = fifo_rd;
    assign rd_data = rd_valid ? fifo_dout : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= fifo_rd;
        end
    end

endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// Bench for fifo_rr_ctrl: directed vector table with driven FIFO flags, then scoreboarded sequences on a FIFO model.
module tb_fifo_rr_ctrl;
    import fifo_rr_ctrl_pkg::*;

    localparam int DATA_W    = 8;
    localparam int N_REQ     = 4;
    localparam int MAX_BURST = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    pop_req;
    logic                    pop_ack;
    logic                    rd_valid;
    logic [DATA_W-1:0]       rd_data;
    logic                    fifo_wr;
    logic                    fifo_rd;
    logic [DATA_W-1:0]       fifo_din;
    logic [DATA_W-1:0]       fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;

    logic              use_model;
    logic              tb_full;
    logic              tb_empty;
    logic [DATA_W-1:0] tb_dout;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    int                count;
    int                wp;
    int                rp;
    logic [DATA_W-1:0] model_dout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic        pop;
        logic        full;
        logic        empty;
        logic [7:0]  dout;
        logic [3:0]  ready;
        logic        wr;
        logic        rd;
        logic        rdv;
        logic [7:0]  din;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vecs [17];

    int          remain [N_REQ];
    logic [7:0]  beat   [N_REQ];
    logic [7:0]  base   [N_REQ];
    logic [7:0]  wr_exp [$];
    logic [7:0]  rd_exp [$];
    int          wr_seen;
    logic        pop_drive;

    fifo_rr_ctrl #(
        .DATA_W    (DATA_W),
        .N_REQ     (N_REQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .pop_req    (pop_req),
        .pop_ack    (pop_ack),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .fifo_wr    (fifo_wr),
        .fifo_rd    (fifo_rd),
        .fifo_din   (fifo_din),
        .fifo_dout  (fifo_dout),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    always #5 clk = ~clk;

    assign fifo_full  = use_model ? (count == FIFO_FULL_LEVEL) : tb_full;
    assign fifo_empty = use_model ? (count == 0) : tb_empty;
    assign fifo_dout  = use_model ? model_dout : tb_dout;

    // Behavioural 16-entry FIFO with a registered read port.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= 0;
            wp         <= 0;
            rp         <= 0;
            model_dout <= '0;
        end else begin
            if (fifo_wr) begin
                mem[wp] <= fifo_din;
                wp      <= (wp + 1) % FIFO_DEPTH;
            end
            if (fifo_rd) begin
                model_dout <= mem[rp];
                rp         <= (rp + 1) % FIFO_DEPTH;
            end
            count <= count + int'(fifo_wr) - int'(fifo_rd);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic p, input logic f,
                                input logic e, input logic [7:0] d, input logic [3:0] rdy,
                                input logic w, input logic rd, input logic rv,
                                input logic [7:0] din, input logic [7:0] rdata);
        vec_t t;
        t.rst = r;  t.valid = v;  t.pop = p;   t.full = f; t.empty = e; t.dout = d;
        t.ready = rdy; t.wr = w;  t.rd = rd;   t.rdv = rv; t.din = din; t.rdata = rdata;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        rst       = v.rst;
        req_valid = v.valid;
        pop_req   = v.pop;
        tb_full   = v.full;
        tb_empty  = v.empty;
        tb_dout   = v.dout;
        #1;
        checkOutput($sformatf("v%0d.ready", idx), 32'(req_ready), 32'(v.ready));
        checkOutput($sformatf("v%0d.wr", idx), 32'(fifo_wr), 32'(v.wr));
        checkOutput($sformatf("v%0d.rd", idx), 32'(fifo_rd), 32'(v.rd));
        checkOutput($sformatf("v%0d.ack", idx), 32'(pop_ack), 32'(v.rd));
        checkOutput($sformatf("v%0d.rdv", idx), 32'(rd_valid), 32'(v.rdv));
        if (v.wr || v.rst) checkOutput($sformatf("v%0d.din", idx), 32'(fifo_din), 32'(v.din));
        if (v.rdv || v.rst) checkOutput($sformatf("v%0d.rdata", idx), 32'(rd_data), 32'(v.rdata));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst       = 1'b1;
        use_model = 1'b1;
        req_valid = '0;
        pop_req   = 1'b0;
        pop_drive = 1'b0;
        wr_seen   = 0;
        wr_exp.delete();
        rd_exp.delete();
        for (int i = 0; i < N_REQ; i++) begin
            remain[i] = 0;
            beat[i]   = '0;
            base[i]   = '0;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle of producer/consumer stimulus plus scoreboard checks on writes and reads.
    task automatic runCycle();
        logic [7:0] e;
        @(negedge clk);
        pop_req = pop_drive;
        for (int i = 0; i < N_REQ; i++) begin
            req_valid[i]         = remain[i] > 0;
            req_data[i*8 +: 8]   = base[i] + beat[i];
        end
        #1;
        if (fifo_full)  checkOutput("wr_while_full", 32'(fifo_wr), 32'd0);
        if (fifo_empty) checkOutput("rd_while_empty", 32'(fifo_rd), 32'd0);
        if (fifo_wr) begin
            wr_seen++;
            if (wr_exp.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL wr_extra: got write 0x%0h, expected none", fifo_din);
            end else begin
                e = wr_exp.pop_front();
                checkOutput("wr_data", 32'(fifo_din), 32'(e));
                rd_exp.push_back(e);
            end
        end
        if (rd_valid) begin
            if (rd_exp.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rd_extra: got rd_data 0x%0h, expected no read", rd_data);
            end else begin
                e = rd_exp.pop_front();
                checkOutput("rd_data", 32'(rd_data), 32'(e));
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                remain[i]--;
                beat[i]++;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        use_model = 1'b0;
        req_valid = '0;
        req_data  = 32'hD0C0B0A0;
        pop_req   = 1'b0;
        pop_drive = 1'b0;
        tb_full   = 1'b0;
        tb_empty  = 1'b1;
        tb_dout   = '0;
        wr_seen   = 0;

        //            rst  valid    pop  full empty dout  | ready    wr   rd   rdv  din    rdata
        vecs[0]  = mk(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 8'h33, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        vecs[1]  = mk(1'b0, 4'b0101, 1'b0, 1'b0, 1'b1, 8'h33, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        vecs[2]  = mk(1'b0, 4'b0101, 1'b0, 1'b0, 1'b1, 8'h33, 4'b0001, 1'b1, 1'b0, 1'b0, 8'hA0, 8'h00);
        vecs[3]  = mk(1'b0, 4'b0101, 1'b1, 1'b0, 1'b0, 8'h33, 4'b0001, 1'b1, 1'b1, 1'b0, 8'hA0, 8'h00);
        vecs[4]  = mk(1'b0, 4'b0101, 1'b0, 1'b1, 1'b0, 8'h77, 4'b0000, 1'b0, 1'b0, 1'b1, 8'h00, 8'h77);
        vecs[5]  = mk(1'b0, 4'b0101, 1'b1, 1'b1, 1'b0, 8'h77, 4'b0000, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        vecs[6]  = mk(1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 8'h5A, 4'b0001, 1'b1, 1'b0, 1'b1, 8'hA0, 8'h5A);
        vecs[7]  = mk(1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 8'h5A, 4'b0001, 1'b1, 1'b0, 1'b0, 8'hA0, 8'h00);
        vecs[8]  = mk(1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 8'h5A, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        vecs[9]  = mk(1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 8'h5A, 4'b0100, 1'b1, 1'b0, 1'b0, 8'hC0, 8'h00);
        vecs[10] = mk(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 8'h5A, 4'b0100, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        vecs[11] = mk(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 8'h5A, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        vecs[12] = mk(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 8'h5A, 4'b0001, 1'b1, 1'b0, 1'b0, 8'hA0, 8'h00);
        vecs[13] = mk(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 8'h5A, 4'b0001, 1'b1, 1'b1, 1'b0, 8'hA0, 8'h00);
        vecs[14] = mk(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 8'h5A, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        vecs[15] = mk(1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 8'h5A, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        vecs[16] = mk(1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 8'h5A, 4'b0001, 1'b1, 1'b0, 1'b0, 8'hA0, 8'h00);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i], i);
        end

        // All producers always valid: rotation 0,1,2,3 with 4,4,4,3 beats until full.
        doReset();
        for (int i = 0; i < N_REQ; i++) begin
            remain[i] = 1000;
            base[i]   = 8'(i * 16);
        end
        for (int p = 0; p < N_REQ; p++) begin
            for (int b = 0; b < ((p == N_REQ - 1) ? 3 : 4); b++) begin
                wr_exp.push_back(8'(p * 16 + b));
            end
        end
        for (int c = 0; c < 40 && wr_seen < 15; c++) runCycle();
        checkOutput("writes_to_full", 32'(wr_seen), 32'd15);
        checkOutput("wr_exp_drained", 32'(wr_exp.size()), 32'd0);
        for (int c = 0; c < 3; c++) begin
            runCycle();
            checkOutput("ready_while_full", 32'(req_ready), 32'd0);
            checkOutput("wr_stalled_full", 32'(fifo_wr), 32'd0);
        end

        // Full with both pending: the read goes first, the held write follows.
        wr_exp.push_back(8'h33);
        pop_drive = 1'b1;
        runCycle();
        checkOutput("both_full_rd", 32'(fifo_rd), 32'd1);
        checkOutput("both_full_wr", 32'(fifo_wr), 32'd0);
        pop_drive = 1'b0;
        runCycle();
        checkOutput("refill_wr", 32'(fifo_wr), 32'd1);
        checkOutput("refill_rdv", 32'(rd_valid), 32'd1);
        runCycle();
        checkOutput("occupancy_back", 32'(count), 32'd15);

        // Empty with a pop pending: no ack until the single write lands.
        doReset();
        remain[1] = 1;
        base[1]   = 8'h5A;
        wr_exp.push_back(8'h5A);
        pop_drive = 1'b1;
        runCycle();
        checkOutput("empty_ack_c1", 32'(pop_ack), 32'd0);
        runCycle();
        checkOutput("empty_ack_c2", 32'(pop_ack), 32'd0);
        checkOutput("empty_wr_c2", 32'(fifo_wr), 32'd1);
        runCycle();
        checkOutput("empty_ack_c3", 32'(pop_ack), 32'd1);
        pop_drive = 1'b0;
        runCycle();
        checkOutput("empty_rdv", 32'(rd_valid), 32'd1);
        checkOutput("empty_rdata", 32'(rd_data), 32'h5A);

        // Producer 1 releases after two beats; the grant then moves to producer 2.
        doReset();
        remain[1] = 2;
        remain[2] = 2;
        base[1]   = 8'h40;
        base[2]   = 8'h80;
        wr_exp.push_back(8'h40);
        wr_exp.push_back(8'h41);
        wr_exp.push_back(8'h80);
        wr_exp.push_back(8'h81);
        runCycle();
        checkOutput("rel_arb_ready", 32'(req_ready), 32'd0);
        runCycle();
        checkOutput("rel_beat1_ready", 32'(req_ready), 32'b0010);
        runCycle();
        checkOutput("rel_beat2_wr", 32'(fifo_wr), 32'd1);
        runCycle();
        checkOutput("rel_drop_wr", 32'(fifo_wr), 32'd0);
        runCycle();
        checkOutput("rel_idle_ready", 32'(req_ready), 32'd0);
        runCycle();
        checkOutput("rel_next_ready", 32'(req_ready), 32'b0100);
        runCycle();
        runCycle();
        checkOutput("rel_exp_drained", 32'(wr_exp.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
